// File: rtl/hm2_gpio_port_mux.sv
// hm2_gpio_port_mux
//   Maps HostMot2 I/O bits and LED requests onto NUM_GPIO expansion headers.
//   Output data and enables are registered. LED requests pass through a
//   retriggerable on-time stretcher. A safe-state request tri-states every
//   pin. Each mapped pin input passes a 2-flop synchroniser and then an
//   agreement filter before it reaches HostMot2.
//
// Ports
//   clk      : sole clock
//   reset_n  : asynchronous active-low reset
//   io_out   : HostMot2 output data            [IO_WIDTH]
//   io_oe    : HostMot2 output enables, 1=drive [IO_WIDTH]
//   io_in    : synchronised, filtered pin data [IO_WIDTH]
//   led_in   : LED requests, 1=on              [LED_COUNT]
//   safe_i   : safe-state request, level sensitive
//   gpio_o   : pin output data                 [NUM_GPIO*GPIO_WIDTH]
//   gpio_oe  : pin output enables              [NUM_GPIO*GPIO_WIDTH]
//   gpio_i   : raw asynchronous pin inputs     [NUM_GPIO*GPIO_WIDTH]
module hm2_gpio_port_mux #(
    parameter int NUM_GPIO   = 2,
    parameter int GPIO_WIDTH = 36,
    parameter int IO_WIDTH   = 72,
    parameter int LED_COUNT  = 2,
    parameter int FILTER_LEN = 4,
    parameter int LED_HOLD   = 5000000
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [IO_WIDTH-1:0]            io_out,
    input  logic [IO_WIDTH-1:0]            io_oe,
    output logic [IO_WIDTH-1:0]            io_in,
    input  logic [LED_COUNT-1:0]           led_in,
    input  logic                           safe_i,
    output logic [NUM_GPIO*GPIO_WIDTH-1:0] gpio_o,
    output logic [NUM_GPIO*GPIO_WIDTH-1:0] gpio_oe,
    input  logic [NUM_GPIO*GPIO_WIDTH-1:0] gpio_i
);

    localparam int MUX_W = IO_WIDTH / NUM_GPIO;
    localparam int LED_W = LED_COUNT / NUM_GPIO;
    localparam int PIN_W = NUM_GPIO * GPIO_WIDTH;
    // LEDs that do not fit behind the I/O pins of a header are left unmapped.
    localparam int LED_FIT = ((GPIO_WIDTH - MUX_W) < LED_W) ? (GPIO_WIDTH - MUX_W) : LED_W;

    localparam int FCNT_W = $clog2(FILTER_LEN + 1);
    localparam logic [FCNT_W-1:0] FLIM = FCNT_W'(FILTER_LEN - 1);

    localparam int LCNT_W = (LED_HOLD > 1) ? $clog2(LED_HOLD) : 1;
    // LED_HOLD=0 loads zero, so the LED simply follows led_in one cycle late.
    localparam logic [LCNT_W-1:0] LLOAD = (LED_HOLD > 0) ? LCNT_W'(LED_HOLD - 1) : '0;

    logic [IO_WIDTH-1:0]  w_pin_in;
    logic [IO_WIDTH-1:0]  r_sync_p0;
    logic [IO_WIDTH-1:0]  r_sync_p1;
    logic [IO_WIDTH-1:0]  r_filt_p2;
    logic [FCNT_W-1:0]    r_fcnt [IO_WIDTH];

    logic [LED_COUNT-1:0] r_led_prev;
    logic [LCNT_W-1:0]    r_led_cnt [LED_COUNT];
    logic [LED_COUNT-1:0] w_led_on;

    logic [PIN_W-1:0]     w_gpio_o_nxt;
    logic [PIN_W-1:0]     w_gpio_oe_nxt;
    logic [PIN_W-1:0]     r_gpio_o;
    logic [PIN_W-1:0]     r_gpio_oe;

    // Idle header pins and unmapped LEDs are intentionally ignored.
    logic w_unused;
    assign w_unused = ^{gpio_i, w_led_on};

    // Pin <-> I/O bit mapping and next-state pin outputs.
    always_comb begin
        w_pin_in      = '0;
        w_gpio_o_nxt  = '0;
        w_gpio_oe_nxt = '0;
        for (int h = 0; h < NUM_GPIO; h++) begin
            for (int p = 0; p < MUX_W; p++) begin
                w_pin_in[h*MUX_W+p]          = gpio_i[h*GPIO_WIDTH+p];
                w_gpio_o_nxt[h*GPIO_WIDTH+p]  = io_out[h*MUX_W+p];
                w_gpio_oe_nxt[h*GPIO_WIDTH+p] = io_oe[h*MUX_W+p];
            end
            for (int q = 0; q < LED_FIT; q++) begin
                w_gpio_o_nxt[h*GPIO_WIDTH+MUX_W+q]  = w_led_on[h*LED_W+q];
                w_gpio_oe_nxt[h*GPIO_WIDTH+MUX_W+q] = 1'b1;
            end
        end
    end

    // LED is lit while requested or while its hold counter is still running.
    always_comb begin
        w_led_on = '0;
        for (int j = 0; j < LED_COUNT; j++) begin
            w_led_on[j] = led_in[j] | (r_led_cnt[j] != '0);
        end
    end

    // ---- stage p0/p1: two-flop synchroniser ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync_p0 <= '0;
            r_sync_p1 <= '0;
        end else begin
            r_sync_p0 <= w_pin_in;
            r_sync_p1 <= r_sync_p0;
        end
    end

    // ---- stage p2: agreement filter ----
    // The count tracks samples that disagree with the current output; it is
    // cleared on any agreeing sample and on the flip, so it never wraps.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_filt_p2 <= '0;
            for (int i = 0; i < IO_WIDTH; i++) begin
                r_fcnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < IO_WIDTH; i++) begin
                if (r_sync_p1[i] == r_filt_p2[i]) begin
                    r_fcnt[i] <= '0;
                end else if (r_fcnt[i] >= FLIM) begin
                    r_filt_p2[i] <= r_sync_p1[i];
                    r_fcnt[i]    <= '0;
                end else begin
                    r_fcnt[i] <= r_fcnt[i] + FCNT_W'(1);
                end
            end
        end
    end

    // LED stretcher: a rising request (re)loads the hold counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_led_prev <= '0;
            for (int j = 0; j < LED_COUNT; j++) begin
                r_led_cnt[j] <= '0;
            end
        end else begin
            r_led_prev <= led_in;
            for (int j = 0; j < LED_COUNT; j++) begin
                if (led_in[j] && !r_led_prev[j]) begin
                    r_led_cnt[j] <= LLOAD;
                end else if (r_led_cnt[j] != '0) begin
                    r_led_cnt[j] <= r_led_cnt[j] - LCNT_W'(1);
                end
            end
        end
    end

    // ---- output register: safe state drops every enable, data keeps updating ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_gpio_o  <= '0;
            r_gpio_oe <= '0;
        end else begin
            r_gpio_o  <= w_gpio_o_nxt;
            r_gpio_oe <= safe_i ? '0 : w_gpio_oe_nxt;
        end
    end

    assign io_in   = r_filt_p2;
    assign gpio_o  = r_gpio_o;
    assign gpio_oe = r_gpio_oe;

endmodule
